// File: rtl/m_issue.sv
// Issue stage for the matrix (GEMM) unit: captures the FUST row, stalls on
// matrix-register hazards, hands off to the FU and owns the pending scoreboard.
module m_issue #(
    parameter int NMREG  = 16,
    parameter int MREG_W = 4,
    parameter int OP_W   = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              fust_valid,
    input  logic [OP_W-1:0]   fust_op,
    input  logic [MREG_W-1:0] fust_md,
    input  logic [MREG_W-1:0] fust_ms1,
    input  logic [MREG_W-1:0] fust_ms2,
    input  logic [MREG_W-1:0] fust_ms3,
    output logic              busy,
    output logic              fu_valid,
    input  logic              fu_ready,
    output logic [OP_W-1:0]   fu_op,
    output logic [MREG_W-1:0] fu_md,
    output logic [MREG_W-1:0] fu_ms1,
    output logic [MREG_W-1:0] fu_ms2,
    output logic [MREG_W-1:0] fu_ms3,
    input  logic              fu_done,
    input  logic              wb_valid,
    input  logic [MREG_W-1:0] wb_md,
    output logic [NMREG-1:0]  pending
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             capture;
    logic             accept;
    logic             hazard;
    logic [NMREG-1:0] pending_nxt;

    assign busy     = (state != S_IDLE);
    assign fu_valid = (state == S_ISSUE);
    assign capture  = (state == S_IDLE) && fust_valid;
    assign accept   = fu_valid && fu_ready;

    // Registered scoreboard only: a writeback this cycle is seen next cycle.
    assign hazard = pending[fu_ms1] | pending[fu_ms2] | pending[fu_ms3] | pending[fu_md];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fust_valid) state_nxt = S_WAIT;
            S_WAIT:  if (!hazard)    state_nxt = S_ISSUE;
            S_ISSUE: if (fu_ready)   state_nxt = S_EXEC;
            S_EXEC:  if (fu_done)    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Set is applied after clear so an accept and writeback to the same index leaves it pending.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid) pending_nxt[wb_md] = 1'b0;
        if (accept)   pending_nxt[fu_md] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= S_IDLE;
            pending <= '0;
            fu_op   <= '0;
            fu_md   <= '0;
            fu_ms1  <= '0;
            fu_ms2  <= '0;
            fu_ms3  <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (capture) begin
                fu_op  <= fust_op;
                fu_md  <= fust_md;
                fu_ms1 <= fust_ms1;
                fu_ms2 <= fust_ms2;
                fu_ms3 <= fust_ms3;
            end
        end
    end

endmodule

// File: doc/m_issue.md
# m_issue

Issue stage for the matrix (GEMM) functional unit. Each cycle it watches the single-row matrix FUST and captures the row when one is valid. It holds the instruction until its source and destination matrix registers are free of pending writes, then hands it to the matrix FU with a valid/ready handshake and tracks it until writeback. It owns the matrix-register pending scoreboard and drives `busy` back to the FUST, which blocks dispatch from loading a new row.

## Interface
Parameters:
- `NMREG`, 16: number of matrix registers.
- `MREG_W`, 4: matrix register index width, equal to clog2(NMREG).
- `OP_W`, 2: matrix opcode width.

Ports:
- `CLK` in 1: single clock. All state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `fust_valid` in 1: FUST row holds an undispatched instruction.
- `fust_op` in OP_W: opcode of the FUST row.
- `fust_md` in MREG_W: destination register D of the FUST row.
- `fust_ms1` in MREG_W: source register A.
- `fust_ms2` in MREG_W: source register B.
- `fust_ms3` in MREG_W: accumulator register C.
- `busy` out 1: issue stage occupied. The FUST clears its row valid on sampling 1, and dispatch must not load the FUST while it is 1.
- `fu_valid` out 1: instruction offered to the matrix FU.
- `fu_ready` in 1: matrix FU accepts the offered instruction.
- `fu_op` out OP_W: latched opcode.
- `fu_md`, `fu_ms1`, `fu_ms2`, `fu_ms3` out MREG_W each: latched register indices.
- `fu_done` in 1: matrix FU finished the accepted instruction. One-cycle pulse.
- `wb_valid` in 1: some unit (matrix FU or matrix load) writes a matrix register this cycle.
- `wb_md` in MREG_W: register index written.
- `pending` out NMREG: scoreboard. Bit i = 1 means a write to register i is outstanding.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - WAIT: row latched, checking hazards.
  - ISSUE: `fu_valid`=1.
  - EXEC: FU running.
  - `busy`=1 in WAIT, ISSUE and EXEC.
- IDLE with `fust_valid`=1: latch op/md/ms1/ms2/ms3 into the `fu_*` registers, then go to WAIT. IDLE with `fust_valid`=0: stay in IDLE.
- WAIT:
  - Hazard = `pending[ms1] | pending[ms2] | pending[ms3] | pending[md]`. The md term covers WAW.
  - No hazard: go to ISSUE. Hazard: stay in WAIT.
  - Use the registered `pending` only, with no same-cycle writeback bypass.
- ISSUE:
  - Hold `fu_valid`=1 and all `fu_*` fields stable until `fu_ready`=1.
  - On `fu_valid & fu_ready`: set `pending[fu_md]`, then go to EXEC.
- EXEC: wait for `fu_done`=1, then go to IDLE. `fu_done` in any other state is ignored.
- Scoreboard:
  - `wb_valid`=1 clears `pending[wb_md]`.
  - If an acceptance and a writeback hit the same index in the same cycle, the set wins and the bit ends at 1.
  - Writeback to an index that is not pending has no effect.
- ms1/ms2/ms3/md may alias each other. Aliasing needs no special handling.
- `fu_*` fields are registered. They hold their last value outside ISSUE and are don't-care when `fu_valid`=0.

## Timing
- Reset (`RST`=1 at an edge): state=IDLE, `busy`=0, `fu_valid`=0, every `fu_*` field = 0, `pending`=0. This applies from any state, including mid-ISSUE or mid-EXEC: an in-flight instruction is dropped and its pending bit is cleared.
- Minimum latency with no hazard:
  - Cycle 0: `fust_valid`=1 in IDLE.
  - Cycle 1: WAIT, `busy`=1.
  - Cycle 2: `fu_valid`=1.
- Writeback to issue: `wb_valid` in cycle n clears `pending` at edge n. WAIT sees the clear in cycle n+1 and `fu_valid`=1 in cycle n+2.
- Acceptance in cycle n: `pending[md]`=1 and state=EXEC from cycle n+1.
- Completion: `fu_done` in cycle n gives IDLE and `busy`=0 in cycle n+1. A new row can be captured in that same cycle n+1.
- A row is never captured twice. `busy` rises the cycle after capture, and the FUST drops `fust_valid` on that edge.

## Test plan
- No-hazard issue:
  - Stimulus: reset, then `fust_valid`=1 with md=3, ms1=1, ms2=2, ms3=3, op=1, `fu_ready` tied to 1.
  - Response: `fu_valid`=1 in cycle 2 with the same fields, then `pending`=0x0008 and EXEC. `fu_done` returns to IDLE one cycle later.
- RAW stall:
  - Stimulus: `pending[5]` set by a prior issue, then a row with ms1=5. `wb_valid`=1 with `wb_md`=5 in cycle 6.
  - Response: stays in WAIT through cycle 6, `fu_valid`=1 in cycle 8.
- Backpressure:
  - Stimulus: `fu_ready`=0 for 4 cycles in ISSUE.
  - Response: `fu_valid` and all `fu_*` fields stable for those 4 cycles. Acceptance happens on the first `fu_ready`=1 cycle.
- Simultaneous set and clear:
  - Stimulus: accept with md=7 in the same cycle as `wb_valid` with `wb_md`=7.
  - Response: `pending[7]`=1 afterwards.
- Reset mid-EXEC:
  - Stimulus: assert `RST` in EXEC with `pending`=0x0080.
  - Response: next cycle IDLE, `busy`=0, `fu_valid`=0, `pending`=0.
